// File: rtl/estagio_ula_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | estagio_ula_if : decode-side and mux-side bus of the execute stage |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface estagio_ula_if #(
  parameter int LARGURA = 32
) ();
  logic               valido_in;
  logic               pronto_out;
  logic [1:0]         alu_op;
  logic [5:0]         funct;
  logic [LARGURA-1:0] op_a;
  logic [LARGURA-1:0] op_b;
  logic               descarta;
  logic               valido_out;
  logic               pronto_in;
  logic [LARGURA-1:0] entrada1;
  logic [LARGURA-1:0] entrada2;
  logic [LARGURA-1:0] entrada3;
  logic [LARGURA-1:0] entrada4;
  logic [LARGURA-1:0] entrada5;
  logic [LARGURA-1:0] entrada6;
  logic [3:0]         seletor;
  logic               overflow;
  logic               erro;

  modport slave (
    input  valido_in, alu_op, funct, op_a, op_b, descarta, pronto_in,
    output pronto_out, valido_out, entrada1, entrada2, entrada3,
           entrada4, entrada5, entrada6, seletor, overflow, erro
  );

  modport master (
    output valido_in, alu_op, funct, op_a, op_b, descarta, pronto_in,
    input  pronto_out, valido_out, entrada1, entrada2, entrada3,
           entrada4, entrada5, entrada6, seletor, overflow, erro
  );
endinterface
`default_nettype wire

// File: rtl/estagio_ula.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | estagio_ula : registered execute-stage front end, decodes the ALU  |
// | code and precomputes all six candidate results for the result mux  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module estagio_ula #(
  parameter int LARGURA = 32
) (
  input  logic         clock,
  input  logic         reset_n,
  estagio_ula_if.slave bus
);
  localparam int MSB = LARGURA - 1;

  localparam logic [3:0] C_OP_AND = 4'b0000;
  localparam logic [3:0] C_OP_OR  = 4'b0001;
  localparam logic [3:0] C_OP_ADD = 4'b0010;
  localparam logic [3:0] C_OP_SUB = 4'b0110;
  localparam logic [3:0] C_OP_SLT = 4'b0111;
  localparam logic [3:0] C_OP_NOR = 4'b1100;

  typedef enum logic {VAZIO = 1'b0, CHEIO = 1'b1} estado_t;

  estado_t r_estado;
  estado_t w_proximo;

  logic               w_valido;
  logic               w_pronto;
  logic               w_aceita;
  logic               w_consome;
  logic [3:0]         w_codigo;
  logic               w_erro;
  logic [LARGURA-1:0] w_soma;
  logic [LARGURA:0]   w_dif_ext;
  logic               w_ovf_add;
  logic               w_ovf_sub;
  logic               w_overflow;

  logic [LARGURA-1:0] r_e1, r_e2, r_e3, r_e4, r_e5, r_e6;
  logic [3:0]         r_seletor;
  logic               r_overflow;
  logic               r_erro;

  assign w_valido  = (r_estado == CHEIO);
  assign w_pronto  = !w_valido || bus.pronto_in;
  assign w_consome = w_valido && bus.pronto_in;
  // A flushed operation must never reach the data registers.
  assign w_aceita  = bus.valido_in && w_pronto && !bus.descarta;

  always_comb begin
    w_codigo = C_OP_ADD;
    w_erro   = 1'b0;
    case (bus.alu_op)
      2'b00: w_codigo = C_OP_ADD;
      2'b01: w_codigo = C_OP_SUB;
      2'b10: begin
        case (bus.funct)
          6'b100100: w_codigo = C_OP_AND;
          6'b100101: w_codigo = C_OP_OR;
          6'b100000: w_codigo = C_OP_ADD;
          6'b100010: w_codigo = C_OP_SUB;
          6'b101010: w_codigo = C_OP_SLT;
          6'b100111: w_codigo = C_OP_NOR;
          default:   w_erro   = 1'b1;
        endcase
      end
      default: w_erro = 1'b1;
    endcase
  end

  // Sign-extended subtraction cannot overflow, so its top bit is the true A<B.
  assign w_soma    = bus.op_a + bus.op_b;
  assign w_dif_ext = {bus.op_a[MSB], bus.op_a} - {bus.op_b[MSB], bus.op_b};
  assign w_ovf_add = (bus.op_a[MSB] == bus.op_b[MSB]) && (w_soma[MSB] != bus.op_a[MSB]);
  assign w_ovf_sub = (bus.op_a[MSB] != bus.op_b[MSB]) && (w_dif_ext[MSB] != bus.op_a[MSB]);

  always_comb begin
    w_overflow = 1'b0;
    if (w_codigo == C_OP_ADD) begin
      w_overflow = w_ovf_add;
    end else if (w_codigo == C_OP_SUB) begin
      w_overflow = w_ovf_sub;
    end
  end

  always_comb begin
    w_proximo = r_estado;
    if (bus.descarta) begin
      w_proximo = VAZIO;
    end else begin
      case (r_estado)
        VAZIO: if (w_aceita) w_proximo = CHEIO;
        CHEIO: begin
          if (w_aceita) begin
            w_proximo = CHEIO;
          end else if (w_consome) begin
            w_proximo = VAZIO;
          end
        end
        default: w_proximo = VAZIO;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_estado <= VAZIO;
    end else begin
      r_estado <= w_proximo;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_e1       <= '0;
      r_e2       <= '0;
      r_e3       <= '0;
      r_e4       <= '0;
      r_e5       <= '0;
      r_e6       <= '0;
      r_seletor  <= 4'b0000;
      r_overflow <= 1'b0;
      r_erro     <= 1'b0;
    end else if (w_aceita) begin
      r_e1       <= bus.op_a & bus.op_b;
      r_e2       <= bus.op_a | bus.op_b;
      r_e3       <= w_soma;
      r_e4       <= w_dif_ext[MSB:0];
      r_e5       <= {{(LARGURA-1){1'b0}}, w_dif_ext[LARGURA]};
      r_e6       <= ~(bus.op_a | bus.op_b);
      r_seletor  <= w_codigo;
      r_overflow <= w_overflow;
      r_erro     <= w_erro;
    end
  end

  assign bus.pronto_out = w_pronto;
  assign bus.valido_out = w_valido;
  assign bus.entrada1   = r_e1;
  assign bus.entrada2   = r_e2;
  assign bus.entrada3   = r_e3;
  assign bus.entrada4   = r_e4;
  assign bus.entrada5   = r_e5;
  assign bus.entrada6   = r_e6;
  assign bus.seletor    = r_seletor;
  assign bus.overflow   = r_overflow;
  assign bus.erro       = r_erro;
endmodule
`default_nettype wire

// File: tb/tb_estagio_ula.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_estagio_ula : scoreboard bench for the execute-stage front end  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_estagio_ula;
  localparam int LARGURA = 32;

  typedef struct packed {
    logic [3:0]  sel;
    logic [31:0] e1, e2, e3, e4, e5, e6;
    logic        ovf;
    logic        err;
  } res_t;

  typedef struct packed {
    logic [1:0]  op;
    logic [5:0]  f;
    logic [31:0] a;
    logic [31:0] b;
  } op_t;

  logic clock   = 1'b0;
  logic reset_n = 1'b1;
  int   total   = 0;
  int   bad     = 0;
  res_t sb[$];

  op_t tab_alu [0:11] = '{
    '{2'b10, 6'b100000, 32'h7FFF_FFFF, 32'h0000_0001},
    '{2'b10, 6'b101010, 32'hFFFF_FFFF, 32'h0000_0001},
    '{2'b10, 6'b101010, 32'h0000_0001, 32'hFFFF_FFFF},
    '{2'b01, 6'b000000, 32'h0000_0005, 32'h0000_0005},
    '{2'b10, 6'b001000, 32'h0000_0003, 32'h0000_0004},
    '{2'b10, 6'b100100, 32'hF0F0_1234, 32'h0FF0_FFFF},
    '{2'b10, 6'b100101, 32'h1200_0034, 32'h0056_7800},
    '{2'b10, 6'b100111, 32'h0000_FFFF, 32'h00FF_0000},
    '{2'b00, 6'b111111, 32'h8000_0000, 32'h8000_0000},
    '{2'b10, 6'b100010, 32'h8000_0000, 32'h0000_0001},
    '{2'b11, 6'b100000, 32'h0000_0001, 32'h0000_0002},
    '{2'b10, 6'b101010, 32'h8000_0000, 32'h0000_0001}
  };

  op_t tab_b2b [0:3] = '{
    '{2'b00, 6'b000000, 32'h0000_0010, 32'h0000_0020},
    '{2'b01, 6'b000000, 32'h0000_0001, 32'h0000_0002},
    '{2'b10, 6'b100100, 32'hDEAD_BEEF, 32'hFFFF_0000},
    '{2'b10, 6'b101010, 32'hFFFF_FFFE, 32'hFFFF_FFFF}
  };

  estagio_ula_if #(.LARGURA(LARGURA)) bus ();

  estagio_ula #(.LARGURA(LARGURA)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  // Reference model: overflow from the exact 64-bit signed result.
  function automatic res_t model(input op_t o);
    res_t   r;
    longint s;
    r     = '0;
    r.sel = 4'b0010;
    case (o.op)
      2'b00: r.sel = 4'b0010;
      2'b01: r.sel = 4'b0110;
      2'b10: begin
        case (o.f)
          6'b100100: r.sel = 4'b0000;
          6'b100101: r.sel = 4'b0001;
          6'b100000: r.sel = 4'b0010;
          6'b100010: r.sel = 4'b0110;
          6'b101010: r.sel = 4'b0111;
          6'b100111: r.sel = 4'b1100;
          default:   r.err = 1'b1;
        endcase
      end
      default: r.err = 1'b1;
    endcase
    r.e1 = o.a & o.b;
    r.e2 = o.a | o.b;
    r.e3 = o.a + o.b;
    r.e4 = o.a - o.b;
    r.e5 = ($signed(o.a) < $signed(o.b)) ? 32'd1 : 32'd0;
    r.e6 = ~(o.a | o.b);
    if (r.sel == 4'b0010) begin
      s     = longint'($signed(o.a)) + longint'($signed(o.b));
      r.ovf = (s != longint'($signed(r.e3)));
    end else if (r.sel == 4'b0110) begin
      s     = longint'($signed(o.a)) - longint'($signed(o.b));
      r.ovf = (s != longint'($signed(r.e4)));
    end
    return r;
  endfunction

  function automatic res_t observe();
    res_t r;
    r.sel = bus.seletor;
    r.e1  = bus.entrada1;
    r.e2  = bus.entrada2;
    r.e3  = bus.entrada3;
    r.e4  = bus.entrada4;
    r.e5  = bus.entrada5;
    r.e6  = bus.entrada6;
    r.ovf = bus.overflow;
    r.err = bus.erro;
    return r;
  endfunction

  task automatic drive(input logic v, input op_t o);
    bus.valido_in = v;
    bus.alu_op    = o.op;
    bus.funct     = o.f;
    bus.op_a      = o.a;
    bus.op_b      = o.b;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    #1;
    reset_n = 1'b0;
    #1;
    total++;
    if (bus.valido_out !== 1'b0) begin
      bad++; $display("FAIL reset_valido: got %b want 0", bus.valido_out);
    end
    total++;
    if (observe() !== res_t'(0)) begin
      bad++; $display("FAIL reset_outputs: got %h want 0", observe());
    end
    total++;
    if (bus.pronto_out !== 1'b1) begin
      bad++; $display("FAIL reset_pronto: got %b want 1", bus.pronto_out);
    end
    step();
    @(negedge clock);
    reset_n = 1'b1;
    step();
    total++;
    if (bus.valido_out !== 1'b0 || bus.pronto_out !== 1'b1) begin
      bad++; $display("FAIL post_reset: valido=%b pronto=%b want 0/1", bus.valido_out, bus.pronto_out);
    end
  endtask

  task automatic test_alu_ops();
    res_t exp;
    res_t got;
    bus.pronto_in = 1'b1;
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, tab_alu[i]);
      sb.push_back(model(tab_alu[i]));
      step();
      drive(1'b0, tab_alu[i]);
      total++;
      if (bus.valido_out !== 1'b1) begin
        bad++; $display("FAIL alu_valido[%0d]: got %b want 1", i, bus.valido_out);
      end
      exp = sb.pop_front();
      got = observe();
      total++;
      if (got !== exp) begin
        bad++; $display("FAIL alu_result[%0d]: got %h want %h", i, got, exp);
      end
      if (i == 0) begin
        total++;
        if ({bus.seletor, bus.entrada3, bus.overflow, bus.erro} !== {4'b0010, 32'h8000_0000, 1'b1, 1'b0}) begin
          bad++; $display("FAIL add_ovf: got sel=%b e3=%h ovf=%b erro=%b", bus.seletor, bus.entrada3, bus.overflow, bus.erro);
        end
      end else if (i == 1 || i == 11) begin
        total++;
        if ({bus.seletor, bus.entrada5} !== {4'b0111, 32'h1}) begin
          bad++; $display("FAIL slt_true[%0d]: got sel=%b e5=%h want 0111/1", i, bus.seletor, bus.entrada5);
        end
      end else if (i == 2) begin
        total++;
        if (bus.entrada5 !== 32'h0) begin
          bad++; $display("FAIL slt_false: got %h want 0", bus.entrada5);
        end
      end else if (i == 3) begin
        total++;
        if ({bus.seletor, bus.entrada4} !== {4'b0110, 32'h0}) begin
          bad++; $display("FAIL sub_eq: got sel=%b e4=%h want 0110/0", bus.seletor, bus.entrada4);
        end
      end else if (i == 4 || i == 10) begin
        total++;
        if ({bus.erro, bus.seletor} !== {1'b1, 4'b0010}) begin
          bad++; $display("FAIL erro[%0d]: got erro=%b sel=%b want 1/0010", i, bus.erro, bus.seletor);
        end
      end
    end
    step();
    total++;
    if (bus.valido_out !== 1'b0) begin
      bad++; $display("FAIL alu_drain: got %b want 0", bus.valido_out);
    end
  endtask

  task automatic test_backpressure();
    op_t  nor_op  = '{2'b10, 6'b100111, 32'hF0F0_F0F0, 32'h0F0F_0000};
    op_t  next_op = '{2'b00, 6'b000000, 32'h0000_0003, 32'h0000_0004};
    res_t exp;
    bus.pronto_in = 1'b0;
    drive(1'b1, nor_op);
    sb.push_back(model(nor_op));
    step();
    drive(1'b1, next_op);
    for (int c = 0; c < 3; c++) begin
      #1;
      total++;
      if (bus.pronto_out !== 1'b0 || bus.valido_out !== 1'b1) begin
        bad++; $display("FAIL bp_hold[%0d]: pronto=%b valido=%b want 0/1", c, bus.pronto_out, bus.valido_out);
      end
      total++;
      if (bus.entrada6 !== 32'h0000_0F0F || observe() !== sb[0]) begin
        bad++; $display("FAIL bp_stable[%0d]: got %h want %h", c, observe(), sb[0]);
      end
      step();
    end
    bus.pronto_in = 1'b1;
    #1;
    total++;
    if (bus.pronto_out !== 1'b1) begin
      bad++; $display("FAIL bp_release: got %b want 1", bus.pronto_out);
    end
    exp = sb.pop_front();
    sb.push_back(model(next_op));
    step();
    drive(1'b0, next_op);
    total++;
    if (bus.valido_out !== 1'b1 || observe() !== sb[0] || observe() === exp) begin
      bad++; $display("FAIL bp_reload: valido=%b got %h want %h", bus.valido_out, observe(), sb[0]);
    end
    void'(sb.pop_front());
    step();
  endtask

  task automatic test_back_to_back();
    res_t exp;
    bus.pronto_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, tab_b2b[i]);
      sb.push_back(model(tab_b2b[i]));
      step();
      total++;
      if (bus.valido_out !== 1'b1) begin
        bad++; $display("FAIL b2b_valido[%0d]: got %b want 1", i, bus.valido_out);
      end
      exp = sb.pop_front();
      total++;
      if (observe() !== exp) begin
        bad++; $display("FAIL b2b_result[%0d]: got %h want %h", i, observe(), exp);
      end
    end
    drive(1'b0, tab_b2b[0]);
    step();
    total++;
    if (bus.valido_out !== 1'b0) begin
      bad++; $display("FAIL b2b_drain: got %b want 0", bus.valido_out);
    end
  endtask

  task automatic test_flush();
    op_t  held = '{2'b10, 6'b100101, 32'h1111_0000, 32'h0000_2222};
    op_t  drop = '{2'b10, 6'b100000, 32'h0000_0100, 32'h0000_0200};
    op_t  post = '{2'b01, 6'b000000, 32'h0000_0009, 32'h0000_000A};
    res_t old;
    res_t exp;
    bus.pronto_in = 1'b0;
    old = model(held);
    drive(1'b1, held);
    step();
    drive(1'b1, drop);
    bus.descarta = 1'b1;
    step();
    bus.descarta = 1'b0;
    drive(1'b0, drop);
    total++;
    if (bus.valido_out !== 1'b0 || bus.pronto_out !== 1'b1) begin
      bad++; $display("FAIL flush_valido: valido=%b pronto=%b want 0/1", bus.valido_out, bus.pronto_out);
    end
    total++;
    if (observe() !== old) begin
      bad++; $display("FAIL flush_stale: got %h want %h", observe(), old);
    end
    bus.pronto_in = 1'b1;
    drive(1'b1, post);
    sb.push_back(model(post));
    step();
    drive(1'b0, post);
    exp = sb.pop_front();
    total++;
    if (bus.valido_out !== 1'b1 || observe() !== exp) begin
      bad++; $display("FAIL flush_recover: valido=%b got %h want %h", bus.valido_out, observe(), exp);
    end
    step();
  endtask

  task automatic test_reset_mid();
    op_t o1 = '{2'b00, 6'b000000, 32'h1234_5678, 32'h1111_1111};
    op_t o2 = '{2'b10, 6'b100111, 32'h0000_0000, 32'h0000_0000};
    bus.pronto_in = 1'b1;
    drive(1'b1, o1);
    sb.push_back(model(o1));
    step();
    drive(1'b1, o2);
    #2;
    reset_n = 1'b0;
    #1;
    total++;
    if (observe() !== res_t'(0) || bus.valido_out !== 1'b0) begin
      bad++; $display("FAIL reset_mid: valido=%b got %h want 0", bus.valido_out, observe());
    end
    total++;
    if (bus.pronto_out !== 1'b1) begin
      bad++; $display("FAIL reset_mid_pronto: got %b want 1", bus.pronto_out);
    end
    sb.delete();
    drive(1'b0, o2);
    @(negedge clock);
    reset_n = 1'b1;
    step();
    total++;
    if (bus.valido_out !== 1'b0) begin
      bad++; $display("FAIL reset_mid_lost: got %b want 0", bus.valido_out);
    end
  endtask

  initial begin
    bus.valido_in = 1'b0;
    bus.alu_op    = 2'b00;
    bus.funct     = 6'b000000;
    bus.op_a      = '0;
    bus.op_b      = '0;
    bus.descarta  = 1'b0;
    bus.pronto_in = 1'b0;
    test_reset();
    test_alu_ops();
    test_backpressure();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
`default_nettype wire

// File: doc/estagio_ula.md
# estagio_ula

Registered execute-stage front end for the 32-bit datapath. It accepts two operands plus `ALUOp`/`funct` from decode through a valid/ready handshake, decodes the 4-bit ALU operation code, and precomputes all six candidate results (AND, OR, ADD, SUB, SLT, NOR). It presents the results and the code, registered, to the downstream 6-input 32-bit result multiplexer. That multiplexer's select input is driven directly by `seletor`.

## Interface
- `LARGURA`, 32, operand and result width; only 32 is supported.
- `clock`  in  1  single clock; all state updates on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `valido_in`  in  1  upstream has a valid operation this cycle.
- `pronto_out`  out  1  stage can accept this cycle.
- `alu_op`  in  2  main-control ALUOp.
- `funct`  in  6  instruction funct field.
- `op_a`, `op_b`  in  32 each  operands.
- `descarta`  in  1  synchronous flush (branch/exception).
- `valido_out`  out  1  registered outputs hold a valid operation.
- `pronto_in`  in  1  downstream consumes when high with `valido_out`.
- `entrada1`..`entrada6`  out  32 each  registered AND, OR, ADD, SUB, SLT, NOR results, in that order.
- `seletor`  out  4  registered operation code.
- `overflow`  out  1  signed overflow of the selected ADD/SUB.
- `erro`  out  1  undecodable `alu_op`/`funct` combination.

## Operation
- Decode of `alu_op`:
  - 00 -> 0010 (ADD).
  - 01 -> 0110 (SUB).
  - 10 -> decoded by `funct`:
    - 100100 -> 0000 (AND).
    - 100101 -> 0001 (OR).
    - 100000 -> 0010 (ADD).
    - 100010 -> 0110 (SUB).
    - 101010 -> 0111 (SLT).
    - 100111 -> 1100 (NOR).
  - 10 with any other `funct`, or `alu_op` = 11 -> `seletor` 0010, `erro` 1.
- Results:
  - `entrada1` = A&B.
  - `entrada2` = A|B.
  - `entrada3` = A+B, mod 2^32.
  - `entrada4` = A-B, mod 2^32.
  - `entrada5` = 32'h1 if A<B signed, else 0. Computed from the true sign, not the sign of the truncated difference.
  - `entrada6` = ~(A|B).
- `overflow`:
  - Code 0010: operands have equal signs and the sum sign differs from them.
  - Code 0110: operands have different signs and the difference sign differs from A.
  - All other codes: 0.
- All outputs are produced for every operation regardless of code; the downstream mux chooses.
- Single-entry pipeline register.
  - `pronto_out` = !`valido_out` || `pronto_in`.
  - Accept = `valido_in` && `pronto_out`.
- State machine has two states:
  - VAZIO: `valido_out`=0. Moves to CHEIO on accept.
  - CHEIO: `valido_out`=1. On accept it reloads and stays CHEIO. On consume without accept it moves to VAZIO. Otherwise it holds.
- `descarta` has priority. The next state is VAZIO whatever `valido_in`/`pronto_in` do; the incoming operation is dropped, and the held one is dropped even if unconsumed.
- Data/flag registers load only on accept (not on flush). After flush they hold stale values while `valido_out`=0.

## Timing
- Reset (async assert, sync-safe deassert handled upstream):
  - `valido_out`=0, `seletor`=0000, `entrada1..6`=0, `overflow`=0, `erro`=0.
  - `pronto_out`=1 during and after reset.
- Latency 1 cycle: an operation accepted at edge N is visible after edge N.
- Throughput 1 op/cycle while `pronto_in` stays high.
- Backpressure:
  - `pronto_in`=0 while CHEIO -> `pronto_out`=0 combinationally.
  - All outputs stay stable until consumed.
- Simultaneous consume and accept in CHEIO -> new data replaces old at the same edge with no bubble.
- `reset_n` low mid-operation -> immediate return to the reset values; the in-flight op is lost.
- `pronto_out` depends combinationally only on `valido_out` and `pronto_in`, not on `valido_in`.

## Test plan
- Reset then R-type ADD, A=7FFFFFFF, B=1, `pronto_in`=1 -> next cycle `seletor`=0010, `entrada3`=80000000, `overflow`=1, `erro`=0, `valido_out`=1.
- SLT, A=FFFFFFFF, B=1 -> `seletor`=0111, `entrada5`=1. Swapped operands -> `entrada5`=0.
- `alu_op`=01, A=5, B=5 -> `seletor`=0110, `entrada4`=0. `funct`=001000 with `alu_op`=10 -> `erro`=1, `seletor`=0010.
- Backpressure: hold `pronto_in`=0 for 3 cycles after a NOR of A=F0F0F0F0, B=0F0F0000 -> `pronto_out`=0, `entrada6`=00000F0F stable throughout. Release -> the next op is accepted the same edge.
- Back-to-back: 4 ops on consecutive cycles with `pronto_in`=1 -> 4 consecutive valid outputs, in order, with no bubble.
- Flush: `descarta`=1 with `valido_in`=1 while CHEIO and `pronto_in`=0 -> next cycle `valido_out`=0. A second test asserts `reset_n`=0 mid-stream -> all outputs are 0 immediately.
